ps2_command_parser: RTL and testbench
=====================================

// Module: ps2_command_parser
// PURPOSE
//  Parametrised keyboard command front end for the step sequencer. Consumes PS/2 scan-code bytes
//  (strobed from the PS/2 receiver or a bench driver) and decodes key sequences into sequencer commands.
//  Sequences: letter key selects a command, decimal digits build a value, Enter commits it. Space toggles play.
//  Filters break (F0) and extended (E0) prefixes. Clamps values to per-command ranges.
//  Sits between the PS/2 receiver and the sequencer control/tempo logic; the live entry value drives the HEX display.
// PARAMETERS
//  VALUE_W     10   width of the accumulated and committed value
//  MAX_DIGITS  3    digits accepted per entry; further digits are dropped and flagged
//  BPM_MIN     40   lower clamp for the BPM command
//  BPM_MAX     300  upper clamp for the BPM command
//  LOOP_MIN    1    lower clamp for the loop-length command
//  LOOP_MAX    16   upper clamp for the loop-length command
//  MUTE_MAX    7    highest valid channel for the mute command; out-of-range is an error, not clamped
// PORTS
//  CLOCK_50      in   1        system clock, 50 MHz
//  reset         in   1        asynchronous, active-high reset
//  scan_code     in   8        scan-code byte
//  scan_valid    in   1        1-cycle strobe; scan_code is valid on the same cycle
//  cmd_valid     out  1        1-cycle pulse; command committed
//  cmd_id        out  2        0=NONE 1=BPM 2=LOOP 3=MUTE; held until the next commit
//  cmd_value     out  VALUE_W  clamped value; held until the next commit
//  play_toggle   out  1        1-cycle pulse on a Space make code
//  entry_active  out  1        high while a command letter has been taken and Enter is pending
//  entry_value   out  VALUE_W  live unclamped accumulator, for the HEX display
//  digit_count   out  2        digits entered so far in the current entry
//  err           out  1        1-cycle pulse: overflow digit, empty Enter, or invalid mute channel
// BEHAVIOUR
//  Reset: every output is 0; the FSM is in IDLE; the accumulator and break/ext flags are cleared.
//  Registered outputs: a response appears on the cycle after the scan_valid strobe.
//  A byte is only acted on when scan_valid=1.
//  Prefix filter, applied in every state:
//   - F0 sets brk. E0 sets ext.
//   - The next non-prefix byte is consumed with no effect; brk and ext are then cleared.
//   - Key releases and extended keys therefore never act.
//  FSM states:
//   - IDLE:
//     - 32(b), 4B(l) or 3A(m): latch the pending id, clear the accumulator and count, go to ENTRY.
//     - 29(Space): pulse play_toggle.
//     - Anything else is ignored.
//   - ENTRY:
//     - Digit make code (45,16,1E,26,25,2E,36,3D,3E,46 = 0..9) with count<MAX_DIGITS:
//       acc=acc*10+d, saturating at 2^VALUE_W-1; count++.
//     - Digit with count==MAX_DIGITS: dropped, err pulse.
//     - Another command letter: restart the entry with the new id.
//     - 76(Esc): abort to IDLE; no cmd, no err.
//     - 29(Space): pulses play_toggle; the entry is kept.
//     - 5A(Enter) with count==0: err pulse, go to IDLE.
//     - 5A(Enter) with count>0: go to COMMIT.
//   - COMMIT (1 cycle):
//     - Clamp the value for BPM/LOOP.
//     - MUTE with acc>MUTE_MAX: err and no cmd.
//     - Otherwise drive cmd_value/cmd_id and pulse cmd_valid; go to IDLE.
//  Latency: cmd_valid asserts 2 cycles after the Enter strobe.
//   - A byte strobed during COMMIT is held in a 1-deep skid register and processed in IDLE; none are lost.
//  entry_active=1 in ENTRY and COMMIT.
//  Repeated make codes (typematic) are treated as fresh presses.
//  Width: acc*10 is computed at VALUE_W+4 bits, then saturated; no wrap-around.
//  Asserting reset mid-entry discards the entry; no cmd_valid results.
// STRUCTURE
//  Package ps2_codes_pkg: scan-code localparams (F0, E0, 5A, 29, 76, letters, digits), the cmd_id enum and the FSM state enum.
//  Sub-module ps2_digit_decode: combinational scan_code -> {is_digit, digit[3:0]}.
//  Top level: FSM, accumulator, clamp, skid register.
// TESTING
//  1 b,9,9,9,Enter -> cmd_valid once; cmd_id=1; cmd_value=300 (clamped); entry_value=999 before commit.
//  2 l,1,Enter then b,2,0,Enter -> LOOP=1, then BPM=40 (20 clamped up); two cmd_valid pulses.
//  3 b,F0,32,1,2,0,F0,16,Enter -> release codes ignored; BPM=120; no err.
//  4 m,9,Enter -> err pulse, no cmd_valid. m,1,2,3,4,Enter -> err on the 4th digit; MUTE 123 -> err.
//  5 Space; F0,29; E0,29 -> exactly one play_toggle. Enter in IDLE -> nothing. b,Enter -> err.
//  6 reset asserted after b,1,2 -> all outputs 0. Then 5,Enter -> ignored. Enter strobe followed by a byte on the next cycle -> byte not lost.

Source files
------------

// File: rtl/ps2_codes_pkg.sv
// Shared scan-code constants, command identifiers and parser FSM states for the
// PS/2 keyboard command front end.
package ps2_codes_pkg;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_KEY_B = 8'h32;
  localparam logic [7:0] SC_KEY_L = 8'h4B;
  localparam logic [7:0] SC_KEY_M = 8'h3A;

  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_BPM  = 2'd1,
    CMD_LOOP = 2'd2,
    CMD_MUTE = 2'd3
  } cmd_id_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_COMMIT = 2'd2
  } parser_state_e;

  // Maps a command letter make code to its command; anything else is CMD_NONE.
  function automatic cmd_id_e letter_to_cmd(input logic [7:0] code);
    case (code)
      SC_KEY_B: letter_to_cmd = CMD_BPM;
      SC_KEY_L: letter_to_cmd = CMD_LOOP;
      SC_KEY_M: letter_to_cmd = CMD_MUTE;
      default:  letter_to_cmd = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_digit_decode.sv
// Combinational decode of a scan-code byte into a decimal digit, if it is one of
// the main-row digit make codes.
module ps2_digit_decode
  import ps2_codes_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic       is_digit,
  output logic [3:0] digit
);

  // Scan code to digit lookup.
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (scan_code)
      SC_D0:   digit = 4'd0;
      SC_D1:   digit = 4'd1;
      SC_D2:   digit = 4'd2;
      SC_D3:   digit = 4'd3;
      SC_D4:   digit = 4'd4;
      SC_D5:   digit = 4'd5;
      SC_D6:   digit = 4'd6;
      SC_D7:   digit = 4'd7;
      SC_D8:   digit = 4'd8;
      SC_D9:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_command_parser.sv
// Keyboard command front end: turns PS/2 make-code sequences (letter, digits, Enter)
// into clamped sequencer commands, with a play toggle on Space.
module ps2_command_parser
  import ps2_codes_pkg::*;
#(
  parameter int VALUE_W    = 10,
  parameter int MAX_DIGITS = 3,
  parameter int BPM_MIN    = 40,
  parameter int BPM_MAX    = 300,
  parameter int LOOP_MIN   = 1,
  parameter int LOOP_MAX   = 16,
  parameter int MUTE_MAX   = 7
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [7:0]         scan_code,
  input  logic               scan_valid,
  output logic               cmd_valid,
  output logic [1:0]         cmd_id,
  output logic [VALUE_W-1:0] cmd_value,
  output logic               play_toggle,
  output logic               entry_active,
  output logic [VALUE_W-1:0] entry_value,
  output logic [1:0]         digit_count,
  output logic               err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_DIGITS);
  localparam logic [VALUE_W-1:0] ACC_MAX    = {VALUE_W{1'b1}};
  localparam logic [VALUE_W-1:0] BPM_MIN_V  = VALUE_W'(BPM_MIN);
  localparam logic [VALUE_W-1:0] BPM_MAX_V  = VALUE_W'(BPM_MAX);
  localparam logic [VALUE_W-1:0] LOOP_MIN_V = VALUE_W'(LOOP_MIN);
  localparam logic [VALUE_W-1:0] LOOP_MAX_V = VALUE_W'(LOOP_MAX);
  localparam logic [VALUE_W-1:0] MUTE_MAX_V = VALUE_W'(MUTE_MAX);

  function automatic logic [VALUE_W-1:0] clamp_value(
    input logic [VALUE_W-1:0] v,
    input logic [VALUE_W-1:0] lo,
    input logic [VALUE_W-1:0] hi
  );
    if (v < lo) begin
      clamp_value = lo;
    end else if (v > hi) begin
      clamp_value = hi;
    end else begin
      clamp_value = v;
    end
  endfunction

  parser_state_e      state_r, state_s;
  cmd_id_e            pend_id_r, pend_id_s;
  logic [VALUE_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               brk_r, brk_s;
  logic               ext_r, ext_s;
  logic [7:0]         skid_r, skid_s;
  logic               skid_vld_r, skid_vld_s;
  logic               cmd_valid_r, cmd_valid_s;
  cmd_id_e            cmd_id_r, cmd_id_s;
  logic [VALUE_W-1:0] cmd_value_r, cmd_value_s;
  logic               play_r, play_s;
  logic               err_r, err_s;

  logic [7:0]         byte_s;
  logic               byte_vld_s;
  logic               is_digit_s;
  logic [3:0]         digit_s;
  cmd_id_e            letter_id_s;
  logic [VALUE_W+3:0] prod_s;
  logic [VALUE_W-1:0] acc_next_s;

  // A byte held over from the commit cycle takes precedence over the live strobe.
  assign byte_s      = skid_vld_r ? skid_r : scan_code;
  assign byte_vld_s  = skid_vld_r | scan_valid;
  assign letter_id_s = letter_to_cmd(byte_s);

  ps2_digit_decode u_digit_decode (
    .scan_code (byte_s),
    .is_digit  (is_digit_s),
    .digit     (digit_s)
  );

  // acc*10 + d computed with 4 bits of headroom, then saturated.
  assign prod_s = ({4'b0000, acc_r} << 3) + ({4'b0000, acc_r} << 1)
                + {{VALUE_W{1'b0}}, digit_s};

  // Saturate the widened accumulator product.
  always_comb begin
    if (|prod_s[VALUE_W+3:VALUE_W]) begin
      acc_next_s = ACC_MAX;
    end else begin
      acc_next_s = prod_s[VALUE_W-1:0];
    end
  end

  // Next-state and registered-output logic for the parser FSM.
  always_comb begin
    state_s     = state_r;
    pend_id_s   = pend_id_r;
    acc_s       = acc_r;
    count_s     = count_r;
    brk_s       = brk_r;
    ext_s       = ext_r;
    skid_s      = skid_r;
    skid_vld_s  = skid_vld_r;
    cmd_valid_s = 1'b0;
    cmd_id_s    = cmd_id_r;
    cmd_value_s = cmd_value_r;
    play_s      = 1'b0;
    err_s       = 1'b0;

    if (state_r == ST_COMMIT) begin
      if (scan_valid && !skid_vld_r) begin
        skid_s     = scan_code;
        skid_vld_s = 1'b1;
      end else begin
        skid_vld_s = skid_vld_r;
      end
      case (pend_id_r)
        CMD_BPM: begin
          cmd_valid_s = 1'b1;
          cmd_id_s    = CMD_BPM;
          cmd_value_s = clamp_value(acc_r, BPM_MIN_V, BPM_MAX_V);
        end
        CMD_LOOP: begin
          cmd_valid_s = 1'b1;
          cmd_id_s    = CMD_LOOP;
          cmd_value_s = clamp_value(acc_r, LOOP_MIN_V, LOOP_MAX_V);
        end
        CMD_MUTE: begin
          if (acc_r > MUTE_MAX_V) begin
            err_s = 1'b1;
          end else begin
            cmd_valid_s = 1'b1;
            cmd_id_s    = CMD_MUTE;
            cmd_value_s = acc_r;
          end
        end
        default: err_s = 1'b0;
      endcase
      state_s = ST_IDLE;
      acc_s   = '0;
      count_s = '0;
    end else begin
      // Draining the skid while a new byte arrives refills it, so nothing is lost.
      if (skid_vld_r && scan_valid) begin
        skid_s     = scan_code;
        skid_vld_s = 1'b1;
      end else begin
        skid_vld_s = 1'b0;
      end

      if (byte_vld_s) begin
        if (byte_s == SC_BRK) begin
          brk_s = 1'b1;
        end else if (byte_s == SC_EXT) begin
          ext_s = 1'b1;
        end else if (brk_r || ext_r) begin
          brk_s = 1'b0;
          ext_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
          if (letter_id_s != CMD_NONE) begin
            pend_id_s = letter_id_s;
            acc_s     = '0;
            count_s   = '0;
            state_s   = ST_ENTRY;
          end else if (byte_s == SC_SPACE) begin
            play_s = 1'b1;
          end else begin
            play_s = 1'b0;
          end
        end else begin
          if (is_digit_s) begin
            if (count_r < MAX_CNT) begin
              acc_s   = acc_next_s;
              count_s = count_r + CNT_W'(1);
            end else begin
              err_s = 1'b1;
            end
          end else if (letter_id_s != CMD_NONE) begin
            pend_id_s = letter_id_s;
            acc_s     = '0;
            count_s   = '0;
          end else if (byte_s == SC_ESC) begin
            acc_s   = '0;
            count_s = '0;
            state_s = ST_IDLE;
          end else if (byte_s == SC_SPACE) begin
            play_s = 1'b1;
          end else if (byte_s == SC_ENTER) begin
            if (count_r == '0) begin
              err_s   = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_COMMIT;
            end
          end else begin
            err_s = 1'b0;
          end
        end
      end else begin
        brk_s = brk_r;
      end
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pend_id_r   <= CMD_NONE;
      acc_r       <= '0;
      count_r     <= '0;
      brk_r       <= 1'b0;
      ext_r       <= 1'b0;
      skid_r      <= 8'h00;
      skid_vld_r  <= 1'b0;
      cmd_valid_r <= 1'b0;
      cmd_id_r    <= CMD_NONE;
      cmd_value_r <= '0;
      play_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      pend_id_r   <= pend_id_s;
      acc_r       <= acc_s;
      count_r     <= count_s;
      brk_r       <= brk_s;
      ext_r       <= ext_s;
      skid_r      <= skid_s;
      skid_vld_r  <= skid_vld_s;
      cmd_valid_r <= cmd_valid_s;
      cmd_id_r    <= cmd_id_s;
      cmd_value_r <= cmd_value_s;
      play_r      <= play_s;
      err_r       <= err_s;
    end
  end

  assign cmd_valid    = cmd_valid_r;
  assign cmd_id       = cmd_id_r;
  assign cmd_value    = cmd_value_r;
  assign play_toggle  = play_r;
  assign entry_active = (state_r == ST_ENTRY) || (state_r == ST_COMMIT);
  assign entry_value  = acc_r;
  assign digit_count  = 2'(count_r);
  assign err          = err_r;

endmodule

// File: tb/tb_ps2_command_parser.sv
// Self-checking bench for ps2_command_parser: expected cmd/err/play events go into a
// scoreboard queue as keys are typed and are matched when the DUT pulses.
module tb_ps2_command_parser;

  localparam logic [1:0] K_CMD  = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_PLAY = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] id;
    logic [9:0] value;
  } exp_t;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [9:0] cmd_value;
  logic       play_toggle;
  logic       entry_active;
  logic [9:0] entry_value;
  logic [1:0] digit_count;
  logic       err;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  ps2_command_parser dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid),
    .cmd_valid    (cmd_valid),
    .cmd_id       (cmd_id),
    .cmd_value    (cmd_value),
    .play_toggle  (play_toggle),
    .entry_active (entry_active),
    .entry_value  (entry_value),
    .digit_count  (digit_count),
    .err          (err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Scoreboard: every output pulse must match the oldest expected event.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (cmd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_cmd: got cmd id=%0d value=%0d, expected no event", cmd_id, cmd_value);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind !== K_CMD || mon_e.id !== cmd_id || mon_e.value !== cmd_value) begin
            errors++;
            $display("FAIL sb_cmd: got cmd id=%0d value=%0d, expected kind=%0d id=%0d value=%0d",
                     cmd_id, cmd_value, mon_e.kind, mon_e.id, mon_e.value);
          end
        end
      end
      if (err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_err: got err pulse, expected no event");
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind !== K_ERR) begin
            errors++;
            $display("FAIL sb_err: got err pulse, expected kind=%0d", mon_e.kind);
          end
        end
      end
      if (play_toggle) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_play: got play_toggle, expected no event");
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind !== K_PLAY) begin
            errors++;
            $display("FAIL sb_play: got play_toggle, expected kind=%0d", mon_e.kind);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] kind, input logic [1:0] id, input logic [9:0] value);
    exp_t e;
    e.kind  = kind;
    e.id    = id;
    e.value = value;
    exp_q.push_back(e);
  endtask

  // One-cycle strobe followed by one idle cycle; starts and ends on a falling edge.
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge CLOCK_50);
    scan_valid = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic drain(input string name);
    wait_cycles(6);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cycles(2);
    checks++;
    if ({cmd_valid, cmd_id, cmd_value, play_toggle, entry_active, entry_value, digit_count, err} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {cmd_valid, cmd_id, cmd_value, play_toggle, entry_active, entry_value, digit_count, err});
    end
    reset = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_bpm_clamp_high;
    send(8'h32); send(8'h46); send(8'h46); send(8'h46);
    checks++;
    if (entry_value !== 10'd999 || digit_count !== 2'd3 || entry_active !== 1'b1) begin
      errors++;
      $display("FAIL bpm_entry: got value=%0d count=%0d active=%b, required 999 3 1",
               entry_value, digit_count, entry_active);
    end
    push_exp(K_CMD, 2'd1, 10'd300);
    scan_code  = 8'h5A;
    scan_valid = 1'b1;
    @(negedge CLOCK_50);
    scan_valid = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || entry_active !== 1'b1) begin
      errors++;
      $display("FAIL bpm_latency1: got cmd_valid=%b active=%b, required 0 1", cmd_valid, entry_active);
    end
    @(negedge CLOCK_50);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_value !== 10'd300) begin
      errors++;
      $display("FAIL bpm_latency2: got cmd_valid=%b value=%0d, required 1 300", cmd_valid, cmd_value);
    end
    @(negedge CLOCK_50);
    checks++;
    if (cmd_valid !== 1'b0 || entry_active !== 1'b0) begin
      errors++;
      $display("FAIL bpm_pulse_end: got cmd_valid=%b active=%b, required 0 0", cmd_valid, entry_active);
    end
    drain("bpm_clamp_high");
  endtask

  task automatic test_loop_then_bpm;
    send(8'h4B); send(8'h16); push_exp(K_CMD, 2'd2, 10'd1); send(8'h5A);
    send(8'h32); send(8'h1E); send(8'h45); push_exp(K_CMD, 2'd1, 10'd40); send(8'h5A);
    drain("loop_then_bpm");
    checks++;
    if (cmd_id !== 2'd1 || cmd_value !== 10'd40) begin
      errors++;
      $display("FAIL cmd_hold: got id=%0d value=%0d, required 1 40", cmd_id, cmd_value);
    end
    // Letter restart, LOOP clamp at both ends.
    send(8'h32); send(8'h2E); send(8'h4B); send(8'h26); push_exp(K_CMD, 2'd2, 10'd3); send(8'h5A);
    send(8'h4B); send(8'h1E); send(8'h2E); push_exp(K_CMD, 2'd2, 10'd16); send(8'h5A);
    send(8'h4B); send(8'h45); push_exp(K_CMD, 2'd2, 10'd1); send(8'h5A);
    drain("loop_clamp");
  endtask

  task automatic test_break_codes;
    send(8'h32); send(8'hF0); send(8'h32);
    send(8'h16); send(8'h1E); send(8'h45);
    send(8'hF0); send(8'h16);
    checks++;
    if (entry_value !== 10'd120 || digit_count !== 2'd3) begin
      errors++;
      $display("FAIL break_entry: got value=%0d count=%0d, required 120 3", entry_value, digit_count);
    end
    push_exp(K_CMD, 2'd1, 10'd120);
    send(8'h5A);
    drain("break_codes");
  endtask

  task automatic test_mute;
    send(8'h3A); send(8'h46); push_exp(K_ERR, 2'd0, 10'd0); send(8'h5A);
    send(8'h3A); send(8'h16); send(8'h1E); send(8'h26);
    push_exp(K_ERR, 2'd0, 10'd0); send(8'h25);
    checks++;
    if (entry_value !== 10'd123) begin
      errors++;
      $display("FAIL mute_overflow_value: got %0d, required 123", entry_value);
    end
    push_exp(K_ERR, 2'd0, 10'd0); send(8'h5A);
    send(8'h3A); send(8'h2E); push_exp(K_CMD, 2'd3, 10'd5); send(8'h5A);
    drain("mute");
  endtask

  task automatic test_play_and_empty;
    push_exp(K_PLAY, 2'd0, 10'd0); send(8'h29);
    send(8'hF0); send(8'h29);
    send(8'hE0); send(8'h29);
    send(8'h5A);
    send(8'h32); push_exp(K_ERR, 2'd0, 10'd0); send(8'h5A);
    send(8'h32); send(8'h26); push_exp(K_PLAY, 2'd0, 10'd0); send(8'h29);
    checks++;
    if (entry_active !== 1'b1 || entry_value !== 10'd3) begin
      errors++;
      $display("FAIL space_keeps_entry: got active=%b value=%0d, required 1 3", entry_active, entry_value);
    end
    send(8'h76);
    checks++;
    if (entry_active !== 1'b0) begin
      errors++;
      $display("FAIL esc_abort: got active=%b, required 0", entry_active);
    end
    drain("play_and_empty");
  endtask

  task automatic test_reset_mid_entry;
    send(8'h32); send(8'h16); send(8'h1E);
    checks++;
    if (entry_value !== 10'd12 || entry_active !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_entry: got value=%0d active=%b, required 12 1", entry_value, entry_active);
    end
    #5 reset = 1'b1;
    #1;
    checks++;
    if ({cmd_valid, cmd_id, cmd_value, play_toggle, entry_active, entry_value, digit_count, err} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h, required 0",
               {cmd_valid, cmd_id, cmd_value, play_toggle, entry_active, entry_value, digit_count, err});
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    send(8'h2E); send(8'h5A);
    drain("reset_mid_entry");
    checks++;
    if (entry_active !== 1'b0 || cmd_id !== 2'd0) begin
      errors++;
      $display("FAIL after_reset_idle: got active=%b id=%0d, required 0 0", entry_active, cmd_id);
    end
  endtask

  task automatic test_back_to_back;
    push_exp(K_CMD, 2'd2, 10'd8);
    scan_valid = 1'b1;
    scan_code  = 8'h4B; @(negedge CLOCK_50);
    scan_code  = 8'h3E; @(negedge CLOCK_50);
    scan_code  = 8'h5A; @(negedge CLOCK_50);
    scan_code  = 8'h32; @(negedge CLOCK_50);
    scan_valid = 1'b0;
    wait_cycles(2);
    checks++;
    if (entry_active !== 1'b1) begin
      errors++;
      $display("FAIL skid_byte: got active=%b, required 1", entry_active);
    end
    send(8'h36); send(8'h45);
    push_exp(K_CMD, 2'd1, 10'd60);
    send(8'h5A);
    drain("back_to_back");
  endtask

  initial begin
    reset      = 1'b1;
    scan_code  = 8'h00;
    scan_valid = 1'b0;
    @(negedge CLOCK_50);
    test_reset;
    test_bpm_clamp_high;
    test_loop_then_bpm;
    test_break_codes;
    test_mute;
    test_play_and_empty;
    test_reset_mid_entry;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
